// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and FSM state encoding for spi_master and spi_slave
package spi_pkg;
   localparam int SPI_DATA_W = 8;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ABORT} spi_state_e;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI serial lines plus tx/rx byte handshake of spi_slave
// ports: sclk/cs/mosi/miso serial, tx_data/tx_valid/tx_ready transmit, rx_data/rx_valid/rx_ack/rx_overrun/busy receive
interface spi_slave_if #(parameter int DATA_W = spi_pkg::SPI_DATA_W);
   logic              sclk, cs, mosi, miso;
   logic [DATA_W-1:0] tx_data, rx_data;
   logic              tx_valid, tx_ready, rx_valid, rx_ack, rx_overrun, busy;
   modport slave (input sclk, cs, mosi, tx_data, tx_valid, rx_ack,
                  output miso, tx_ready, rx_data, rx_valid, rx_overrun, busy);
   modport master (output sclk, cs, mosi, tx_data, tx_valid, rx_ack,
                   input miso, tx_ready, rx_data, rx_valid, rx_overrun, busy);
endinterface

// File: rtl/spi_sync.sv
// spi_sync: STAGES-flop synchronizer with asynchronous active-high reset
// ports: clk, rst, d_i async input, q_o synchronized output
module spi_sync #(parameter int STAGES = 2) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   // keep the low STAGES bits of {sync_q, d_i}: shift in at bit 0
   always_ff @(posedge clk or posedge rst)
      if (rst) sync_q <= '0;
      else     sync_q <= STAGES'({sync_q, d_i});
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 MSB-first slave with one-deep tx buffer and rx holding register
// ports: sys_clk, reset (async active-high), bus (spi_slave_if.slave: serial lines, tx/rx handshake, busy)
module spi_slave #(
   parameter int DATA_W      = spi_pkg::SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input logic          sys_clk,
   input logic          reset,
   spi_slave_if.slave   bus
);
   import spi_pkg::*;
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic sclk_s, cs_s, mosi_s, sclk_prev_q, cs_prev_q;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic in_shift, wrap, load, capture, ack;
   spi_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
   logic              tx_full_q, tx_full_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(sys_clk), .rst(reset), .d_i(bus.sclk), .q_o(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(sys_clk), .rst(reset), .d_i(bus.cs),   .q_o(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(sys_clk), .rst(reset), .d_i(bus.mosi), .q_o(mosi_s));

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign cs_fall   = ~cs_s & cs_prev_q;

   always_comb begin
      in_shift   = state_q == ST_SHIFT;
      wrap       = in_shift & sclk_rise & (cnt_q == CW'(DATA_W - 1));
      load       = (state_q == ST_IDLE & cs_rise) | wrap;
      capture    = bus.tx_valid & ~tx_full_q;
      ack        = bus.rx_ack & rx_valid_q;
      state_d    = state_q == ST_IDLE  ? (cs_rise ? ST_SHIFT : ST_IDLE) :
                   state_q == ST_SHIFT ? (cs_fall ? (cnt_q == '0 ? ST_IDLE : ST_ABORT) : ST_SHIFT) :
                   ST_IDLE;
      cnt_d      = ~in_shift ? '0 : sclk_rise ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
      rx_sh_d    = ~in_shift ? '0 : sclk_rise ? {rx_sh_q[DATA_W-2:0], mosi_s} : rx_sh_q;
      // the falling edge right after a wrap (count 0) must not shift: the fresh byte's MSB is already on miso
      tx_sh_d    = load ? (tx_full_q ? tx_buf_q : '0) :
                   (in_shift & sclk_fall & cnt_q != '0) ? {tx_sh_q[DATA_W-2:0], 1'b0} : tx_sh_q;
      // a capture in the load cycle refills the buffer just emptied by the load
      tx_full_d  = load ? capture : tx_full_q | capture;
      tx_buf_d   = capture ? bus.tx_data : tx_buf_q;
      rx_data_d  = wrap ? {rx_sh_q[DATA_W-2:0], mosi_s} : rx_data_q;
      rx_valid_d = wrap | (rx_valid_q & ~ack);
      ovr_d      = wrap ? (ovr_q | (rx_valid_q & ~ack)) : ovr_q & ~ack;
   end

   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         tx_buf_q    <= '0;
         tx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         tx_buf_q    <= tx_buf_d;
         tx_full_q   <= tx_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         ovr_q       <= ovr_d;
      end

   assign bus.miso       = in_shift & tx_sh_q[DATA_W-1];
   assign bus.tx_ready   = ~tx_full_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_overrun = ovr_q;
   assign bus.busy       = in_shift;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with a mode-0 master model
module tb_spi_slave;
   localparam int H = 8;
   logic sys_clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] s1, s2;

   spi_slave_if #(.DATA_W(8)) bus ();
   spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus.slave));

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic push(input logic [7:0] d);
      bus.tx_data = d; bus.tx_valid = 1'b1; ticks(1); bus.tx_valid = 1'b0;
   endtask

   task automatic do_ack();
      bus.rx_ack = 1'b1; ticks(1); bus.rx_ack = 1'b0;
   endtask

   task automatic cs_up();
      bus.cs = 1'b1; ticks(H);
   endtask

   task automatic cs_down();
      bus.cs = 1'b0; ticks(H);
   endtask

   task automatic bits(input logic [7:0] m, input int n, output logic [7:0] s);
      s = '0;
      for (int i = 0; i < n; i++) begin
         bus.mosi = m[7-i];
         ticks(H);
         s = {s[6:0], bus.miso};
         bus.sclk = 1'b1;
         ticks(H);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_miso"}, bus.miso, 0);
      chk({tag, "_tx_ready"}, bus.tx_ready, 1);
      chk({tag, "_rx_data"}, bus.rx_data, 0);
      chk({tag, "_rx_valid"}, bus.rx_valid, 0);
      chk({tag, "_overrun"}, bus.rx_overrun, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   initial begin
      bus.sclk = 0; bus.cs = 0; bus.mosi = 0; bus.tx_data = 0; bus.tx_valid = 0; bus.rx_ack = 0;
      ticks(3);
      chk_reset_outs("rst");
      reset = 1'b0;
      ticks(4);
      // single byte
      push(8'hA3);
      chk("single_tx_ready_low", bus.tx_ready, 0);
      cs_up();
      chk("single_busy", bus.busy, 1);
      chk("single_tx_ready_after_load", bus.tx_ready, 1);
      bits(8'h55, 8, s1);
      chk("single_rx_data", bus.rx_data, 8'h55);
      chk("single_rx_valid", bus.rx_valid, 1);
      chk("single_master_in", s1, 8'hA3);
      cs_down();
      chk("single_busy_done", bus.busy, 0);
      do_ack();
      chk("single_ack", bus.rx_valid, 0);
      // back-to-back frames with cs held
      push(8'hC0);
      cs_up();
      push(8'h0F);
      bits(8'h12, 8, s1);
      chk("b2b_rx1", bus.rx_data, 8'h12);
      chk("b2b_valid1", bus.rx_valid, 1);
      do_ack();
      chk("b2b_ack1", bus.rx_valid, 0);
      bits(8'h34, 8, s2);
      chk("b2b_rx2", bus.rx_data, 8'h34);
      chk("b2b_valid2", bus.rx_valid, 1);
      chk("b2b_overrun", bus.rx_overrun, 0);
      chk("b2b_miso1", s1, 8'hC0);
      chk("b2b_miso2", s2, 8'h0F);
      cs_down();
      do_ack();
      // overrun
      cs_up();
      bits(8'hAA, 8, s1);
      chk("ovr_first_flag", bus.rx_overrun, 0);
      bits(8'hBB, 8, s1);
      chk("ovr_rx", bus.rx_data, 8'hBB);
      chk("ovr_flag", bus.rx_overrun, 1);
      chk("ovr_valid", bus.rx_valid, 1);
      cs_down();
      do_ack();
      chk("ovr_ack_valid", bus.rx_valid, 0);
      chk("ovr_ack_flag", bus.rx_overrun, 0);
      // abort after 5 bits
      cs_up();
      bits(8'hE7, 5, s1);
      cs_down();
      chk("abort_valid", bus.rx_valid, 0);
      chk("abort_rx_kept", bus.rx_data, 8'hBB);
      chk("abort_busy", bus.busy, 0);
      cs_up();
      bits(8'h81, 8, s1);
      chk("abort_next_rx", bus.rx_data, 8'h81);
      chk("abort_next_valid", bus.rx_valid, 1);
      cs_down();
      do_ack();
      // underrun: empty buffer sends zeros
      chk("under_tx_ready", bus.tx_ready, 1);
      cs_up();
      bits(8'hF0, 8, s1);
      chk("under_master_in", s1, 8'h00);
      chk("under_rx", bus.rx_data, 8'hF0);
      cs_down();
      do_ack();
      // reset mid-frame
      push(8'h5A);
      cs_up();
      push(8'h77);
      chk("rstmid_tx_full", bus.tx_ready, 0);
      bits(8'hFF, 3, s1);
      #2 reset = 1'b1;
      #1 chk_reset_outs("rstmid");
      bus.cs = 0; bus.sclk = 0;
      ticks(2);
      reset = 1'b0;
      ticks(H);
      chk("rstmid_idle_busy", bus.busy, 0);
      chk("rstmid_idle_valid", bus.rx_valid, 0);
      cs_up();
      bits(8'h3C, 8, s1);
      chk("rstmid_rx", bus.rx_data, 8'h3C);
      chk("rstmid_valid", bus.rx_valid, 1);
      chk("rstmid_master_in", s1, 8'h00);
      cs_down();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the frame width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sclk, cs and mosi.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: sys_clk (in, 1, system clock) and reset (in, 1, asynchronous active-high reset).
REQ-004 SHALL have these serial ports: sclk (in, 1, serial clock from spi_master), cs (in, 1, active-high slave select as driven by spi_master), mosi (in, 1, serial data in) and miso (out, 1, serial data out).
REQ-005 SHALL have these transmit ports: tx_data (in, DATA_W, next byte to send), tx_valid (in, 1, tx_data offered) and tx_ready (out, 1, tx buffer empty).
REQ-006 SHALL have these receive ports: rx_data (out, DATA_W, last received byte), rx_valid (out, 1, rx_data unread), rx_ack (in, 1, consumer has read rx_data), rx_overrun (out, 1, sticky overwrite flag) and busy (out, 1, frame in progress).

Function
REQ-007 SHALL use SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample mosi on sclk rising edges and change miso on sclk falling edges.
REQ-008 SHALL pass sclk, cs and mosi through SYNC_STAGES flops, then detect edges by comparing each synchronized signal with a one-cycle-delayed copy.
REQ-009 SHALL support sclk periods of at least 8 sys_clk periods; slower sclk rates have no other constraint.
REQ-010 SHALL implement a state machine with states IDLE, SHIFT and ABORT:
- IDLE -> SHIFT on a synchronized cs rising edge.
- SHIFT -> IDLE on a cs falling edge when the bit count is 0.
- SHIFT -> ABORT on a cs falling edge when the bit count is nonzero.
- ABORT -> IDLE after 1 cycle.
REQ-011 SHALL, on entry to SHIFT, load the tx shift register from the tx buffer and mark the buffer empty; if the buffer is empty, it SHALL load all zeros.
REQ-012 SHALL drive miso from the tx shift MSB while in SHIFT, and drive miso to 0 in IDLE and ABORT.
REQ-013 SHALL count sclk rising edges with a 0..DATA_W-1 counter that wraps.
REQ-014 SHALL, when the counter wraps, perform all of the following in the same cycle:
- copy the rx shift register to rx_data;
- set rx_valid;
- reload the tx shift register from the tx buffer (or zeros), allowing back-to-back frames without deasserting cs.
REQ-015 SHALL set rx_valid no later than SYNC_STAGES+2 sys_clk cycles after the final sclk rising edge arrives at the pin.
REQ-016 SHALL hold rx_valid until an rx_ack cycle; rx_ack while rx_valid=0 SHALL be ignored.
REQ-017 SHALL, if a byte completes while rx_valid=1 and rx_ack=0, overwrite rx_data, keep rx_valid=1 and set rx_overrun; if completion and rx_ack coincide, it SHALL clear neither flag and SHALL NOT set rx_overrun.
REQ-018 SHALL clear rx_overrun only on an rx_ack cycle or on reset.
REQ-019 SHALL drive tx_ready = 1 whenever the tx buffer is empty; a tx_valid&&tx_ready cycle SHALL capture tx_data into the buffer and drop tx_ready on the next cycle.
REQ-020 SHALL, if a capture and a load coincide, load the old buffer contents into the shifter and keep the newly captured byte in the buffer.
REQ-021 SHALL, on ABORT, discard the partial rx byte, leave rx_data and rx_valid unchanged, reset the counter to 0, and not refill the tx buffer.
REQ-022 SHALL drive busy = 1 exactly while in SHIFT.

Reset
REQ-023 SHALL, on reset assertion, immediately force all of the following:
- state IDLE and bit counter 0;
- shift registers and tx buffer cleared, buffer marked empty;
- outputs miso=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, busy=0;
- all synchronizer flops cleared.
REQ-024 SHALL, when reset is asserted mid-frame, drop the partial frame, and SHALL not resume that frame after release; a new cs rising edge is required.

Structure
REQ-025 SHALL take DATA_W's default and the state encoding (IDLE/SHIFT/ABORT) from shared package spi_pkg, which spi_master also uses.
REQ-026 SHALL instantiate sub-module spi_sync (a parameterized SYNC_STAGES-flop synchronizer with asynchronous reset) three times, for sclk, cs and mosi.

Verification
REQ-027 SHALL verify single byte: tx_data=0xA3 preloaded, spi_master sends 0x55 -> rx_data=0x55, rx_valid=1, master out_reg=0xA3, busy back to 0.
REQ-028 SHALL verify back-to-back: cs held high, 0x12 then 0x34 received with tx 0xC0 then 0x0F -> two rx_valid events (ack between them), miso carries 0xC0 then 0x0F, rx_overrun=0.
REQ-029 SHALL verify overrun: two bytes 0xAA and 0xBB received with no rx_ack -> rx_data=0xBB, rx_overrun=1; rx_ack -> rx_valid=0, rx_overrun=0.
REQ-030 SHALL verify abort: cs dropped after 5 sclk rising edges -> no rx_valid, state returns to IDLE; the next full frame with 0x81 -> rx_data=0x81.
REQ-031 SHALL verify underrun: no tx_valid before the frame -> miso=0 for all 8 bits, master out_reg=0x00.
REQ-032 SHALL verify reset mid-frame: reset pulsed after 3 bits -> all outputs at reset values; the following full frame with 0x3C -> rx_data=0x3C.
